// File: rtl/sram_read_streamer_if.sv
// Command, SRAM read-port and output-stream bundle for sram_read_streamer.
// cmd_stride exists only when SRAM_READ_STREAMER_STRIDE_EN is defined.
interface sram_read_streamer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
`ifdef SRAM_READ_STREAMER_STRIDE_EN
  logic [ADDR_W-1:0] cmd_stride;
`endif
  logic [ADDR_W-1:0] sram_address;
  logic              sram_chipselect;
  logic              sram_write;
  logic [DATA_W/8-1:0] sram_byteenable;
  logic              sram_clken;
  logic [DATA_W-1:0] sram_readdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
`ifdef SRAM_READ_STREAMER_STRIDE_EN
    input  cmd_stride,
`endif
    input  sram_readdata, out_ready,
    output cmd_ready, sram_address,
    output sram_chipselect, sram_write,
    output sram_byteenable, sram_clken,
    output out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
`ifdef SRAM_READ_STREAMER_STRIDE_EN
    output cmd_stride,
`endif
    output sram_readdata, out_ready,
    input  cmd_ready, sram_address,
    input  sram_chipselect, sram_write,
    input  sram_byteenable, sram_clken,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/sram_read_streamer.sv
// Streams a block of SRAM words (1-cycle read port) into a credit-limited FIFO.
// Define SRAM_READ_STREAMER_STRIDE_EN to add a per-command address stride.
module sram_read_streamer #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  sram_read_streamer_if.master bus,
  output logic busy,
  output logic done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [ADDR_W:0] ONE = 1;

  logic [1:0]        state;
  logic              live;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] stride;
  logic [ADDR_W:0]   rem;
  logic              pend;
  logic              pend_last;
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     count;
  logic [CW-1:0]     credit;
  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic              accept;
  logic              issue;
  logic              pop;
  logic              head_last;

  assign bus.cmd_ready = live & (state == IDLE);
  assign accept = bus.cmd_valid & bus.cmd_ready;

  // Occupancy plus the read in flight may never exceed the FIFO size.
  assign credit = count + CW'(pend);
  assign issue  = (state == RUN)
                & (credit < CW'(FIFO_DEPTH));

  assign bus.sram_address    = addr;
  assign bus.sram_chipselect = issue;
  assign bus.sram_write      = 1'b0;
  assign bus.sram_byteenable = '1;
  assign bus.sram_clken      = 1'b1;

  assign head_last     = mem[rp][DATA_W];
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rp][DATA_W-1:0];
  assign bus.out_last  = bus.out_valid & head_last;
  assign pop           = bus.out_valid & bus.out_ready;

  assign busy = (state != IDLE);

`ifdef SRAM_READ_STREAMER_STRIDE_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      stride <= '0;
    else if (accept)
      stride <= bus.cmd_stride;
  end
`else
  assign stride = ADDR_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset_n && pend)
      mem[wp] <= {pend_last, bus.sram_readdata};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      live      <= 1'b0;
      addr      <= '0;
      rem       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      done      <= 1'b0;
    end else begin
      live      <= 1'b1;
      done      <= 1'b0;
      pend      <= issue;
      pend_last <= issue & (rem == ONE);
      if (pend)
        wp <= wp + PW'(1);
      if (pop)
        rp <= rp + PW'(1);
      count <= count + CW'(pend) - CW'(pop);
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            addr <= bus.cmd_addr;
            rem  <= bus.cmd_len;
            if (bus.cmd_len == '0)
              done <= 1'b1;
            else
              state <= RUN;
          end
        end
        (state == RUN): begin
          if (issue) begin
            addr <= addr + stride;
            rem  <= rem - ONE;
            if (rem == ONE)
              state <= DRAIN;
          end
        end
        (state == DRAIN): begin
          if (pop && head_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_read_streamer.sv
// Directed-vector bench for sram_read_streamer with a behavioural SRAM.
// Build with SRAM_READ_STREAMER_STRIDE_EN to include the stride vectors.
module tb_sram_read_streamer;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  typedef struct {
    int addr;
    int len;
    int stride;
    int rmode;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic last;
    int edge_n;
  } beat_t;

  logic clk;
  logic reset_n;
  logic busy;
  logic done;

  sram_read_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_read_streamer #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge, done_edge, cs_cnt;
  int issued, popped, max_out, unstable;
  int rmode = 0;
  int rcnt = 0;
  logic stall_q;
  logic [DW-1:0] stall_d;
  logic stall_l;
  beat_t beats[$];
  vec_t vecs[$];

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {2'b00, a} * 16'd3 + 16'h1234;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.sram_chipselect)
      bus.sram_readdata <= word(bus.sram_address);

  always @(negedge clk) begin
    rcnt = rcnt + 1;
    case (rmode)
      1: bus.out_ready = rcnt[0];
      2: bus.out_ready = (rcnt >= 6 && rcnt < 16)
                         ? 1'b0 : rcnt[0];
      default: bus.out_ready = 1'b1;
    endcase
  end

  // Observes each cycle just after inputs settle; events take effect at edge cyc+1.
  always begin
    @(negedge clk);
    #1;
    if (!reset_n) begin
      issued  = 0;
      popped  = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q && !(bus.out_valid
          && bus.out_data == stall_d
          && bus.out_last == stall_l))
        unstable++;
      if (bus.cmd_valid && bus.cmd_ready)
        acc_edge = cyc + 1;
      if (done)
        done_edge = cyc;
      if (bus.sram_chipselect) begin
        cs_cnt++;
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        beats.push_back('{data: bus.out_data,
          last: bus.out_last, edge_n: cyc + 1});
        popped++;
      end
      if (issued - popped > max_out)
        max_out = issued - popped;
      stall_q = bus.out_valid && !bus.out_ready;
      stall_d = bus.out_data;
      stall_l = bus.out_last;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic clear_mon();
    beats.delete();
    acc_edge  = -1;
    done_edge = -1;
    cs_cnt    = 0;
    max_out   = 0;
    unstable  = 0;
  endtask

  task automatic send_cmd(input vec_t v);
    int n;
    rmode = v.rmode;
    rcnt  = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(v.addr);
    bus.cmd_len   = (AW+1)'(v.len);
`ifdef SRAM_READ_STREAMER_STRIDE_EN
    bus.cmd_stride = AW'(v.stride);
`endif
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", n < 20, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    chk("busy_after_accept", busy, v.len > 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int ea;
    clear_mon();
    send_cmd(v);
    n = 0;
    while (done_edge < 0 && n < 400) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk($sformatf("v%0d_done_wait", idx), n < 400, 1);
    chk($sformatf("v%0d_beats", idx),
        beats.size(), v.len);
    foreach (beats[i]) begin
      ea = (v.addr + i * v.stride) % (1 << AW);
      chk($sformatf("v%0d_data%0d", idx, i),
          beats[i].data, word(AW'(ea)));
      chk($sformatf("v%0d_last%0d", idx, i),
          beats[i].last, i == v.len - 1);
    end
    if (v.len == 0) begin
      chk($sformatf("v%0d_no_cs", idx), cs_cnt, 0);
      chk($sformatf("v%0d_done_lat", idx),
          done_edge - acc_edge, 0);
      chk($sformatf("v%0d_ready_kept", idx),
          bus.cmd_ready, 1);
    end else if (beats.size() > 0) begin
      chk($sformatf("v%0d_done_after_last", idx),
          done_edge, beats[beats.size()-1].edge_n);
      if (v.rmode == 0) begin
        chk($sformatf("v%0d_first_lat", idx),
            beats[0].edge_n - acc_edge, 3);
        chk($sformatf("v%0d_last_lat", idx),
            beats[beats.size()-1].edge_n - acc_edge,
            v.len + 2);
      end
    end
    chk($sformatf("v%0d_outstanding_ok", idx),
        max_out <= DEPTH, 1);
    chk($sformatf("v%0d_stable", idx), unstable, 0);
    chk($sformatf("v%0d_idle_busy", idx), busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    chk({tag, "_cs"}, bus.sram_chipselect, 0);
    chk({tag, "_addr"}, bus.sram_address, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    int n;
    vecs.push_back('{'h0010, 8, 1, 0});
    vecs.push_back('{'h3FFE, 4, 1, 0});
    vecs.push_back('{'h0200, 16, 1, 2});
    vecs.push_back('{'h0055, 1, 1, 0});
    vecs.push_back('{'h0123, 0, 1, 0});
    vecs.push_back('{'h0300, 5, 1, 1});
`ifdef SRAM_READ_STREAMER_STRIDE_EN
    vecs.push_back('{'h0000, 4, 'h100, 0});
    vecs.push_back('{'h0020, 3, 0, 1});
`endif

    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
`ifdef SRAM_READ_STREAMER_STRIDE_EN
    bus.cmd_stride = '0;
`endif
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("rst");
    chk("tie_write", bus.sram_write, 0);
    chk("tie_be", bus.sram_byteenable, 2'b11);
    chk("tie_clken", bus.sram_clken, 1);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ready_after_rst", bus.cmd_ready, 1);

    foreach (vecs[i])
      run_vec(vecs[i], i);

    // Reset partway through an 8-word command.
    clear_mon();
    send_cmd('{'h0040, 8, 1, 0});
    n = 0;
    while (beats.size() < 3 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("mid_rst_wait", n < 100, 1);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_vals("mid_rst");
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_ready", bus.cmd_ready, 1);
    run_vec('{'h0100, 2, 1, 0}, 99);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
